ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter; the send-side counterpart of the keyboard scan-code receiver.

---
 rtl/ps2_host_tx.sv | 172 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends one command byte
// with odd parity and stop bit, then checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t state, state_n;

  logic                  clk_meta, clk_sync, dat_meta, dat_sync;
  logic [FILTER_LEN-1:0] clk_hist;
  logic                  clk_filt;
  logic                  fall;

  logic [9:0]       shift_reg;
  logic [3:0]       bit_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;

  logic clk_oe_n, dat_oe_n, done_n, err_n;
  logic accept, inh_done, timeout, in_frame;

  // Filtered clock only moves once every sample in the history agrees;
  // fall fires in the cycle the all-low history is seen, so DAT updates on the next edge.
  assign fall     = clk_filt && (clk_hist == '0);
  assign tx_ready = (state == IDLE);
  assign accept   = tx_valid && tx_ready;
  assign inh_done = (inh_cnt == INH_W'(INHIBIT_CYCLES - 1));
  assign timeout  = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign in_frame = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
      clk_hist <= '1;
      clk_filt <= 1'b1;
    end else begin
      clk_meta <= PS2_CLK;
      clk_sync <= clk_meta;
      dat_meta <= PS2_DAT;
      dat_sync <= dat_meta;
      clk_hist <= {clk_hist[FILTER_LEN-2:0], clk_sync};
      if (clk_hist == '0)
        clk_filt <= 1'b0;
      else if (&clk_hist)
        clk_filt <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      inh_cnt    <= '0;
      to_cnt     <= '0;
    end else begin
      state      <= state_n;
      ps2_clk_oe <= clk_oe_n;
      ps2_dat_oe <= dat_oe_n;
      tx_done    <= done_n;
      tx_error   <= err_n;
      if (accept) begin
        shift_reg <= {1'b1, ~^tx_data, tx_data};
        inh_cnt   <= '0;
      end else if (state == INHIBIT) begin
        inh_cnt <= inh_cnt + 1'b1;
      end
      if (state == INHIBIT && inh_done) begin
        bit_cnt <= '0;
        to_cnt  <= '0;
      end else if (in_frame) begin
        to_cnt <= to_cnt + 1'b1;
        if (state == SEND && fall && !timeout)
          bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    clk_oe_n = 1'b0;
    dat_oe_n = ps2_dat_oe;
    done_n   = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        dat_oe_n = 1'b0;
        if (accept) begin
          state_n  = INHIBIT;
          clk_oe_n = 1'b1;
        end
      end
      INHIBIT: begin
        clk_oe_n = 1'b1;
        dat_oe_n = 1'b0;
        // Start bit goes out in the same cycle CLK is released.
        if (inh_done) begin
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b1;
          state_n  = SEND;
        end
      end
      SEND: begin
        if (fall) begin
          dat_oe_n = ~shift_reg[bit_cnt];
          if (bit_cnt == 4'd9)
            state_n = ACK;
        end
      end
      ACK: begin
        if (fall) begin
          if (!dat_sync) begin
            state_n = WAIT_IDLE;
          end else begin
            state_n  = IDLE;
            dat_oe_n = 1'b0;
            err_n    = 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_filt && dat_sync) begin
          state_n  = IDLE;
          dat_oe_n = 1'b0;
          done_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Timeout overrides any same-cycle fall or completion.
    if (in_frame && timeout) begin
      state_n  = IDLE;
      clk_oe_n = 1'b0;
      dat_oe_n = 1'b0;
      done_n   = 1'b0;
      err_n    = 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model drives the pads while a timeline
// model predicts every output each cycle from accept time and pad-edge times.
module tb_ps2_host_tx;
  localparam int N    = 60;    // inhibit cycles
  localparam int T    = 2000;  // timeout cycles
  localparam int HALF = 20;    // device clock half-period in system cycles
  localparam int LAT  = 11;    // pad fall to DAT update: 2 sync + 8 filter + 1

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       dev_clk = 1'b1, dev_dat = 1'b1;
  logic       tx_ready, clk_oe, dat_oe, tx_done, tx_error;
  logic       pad_clk, pad_dat;

  assign pad_clk = dev_clk & ~clk_oe;
  assign pad_dat = dev_dat & ~dat_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(N), .FILTER_LEN(8), .TIMEOUT_CYCLES(T)) dut (
    .CLOCK_50(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .PS2_CLK(pad_clk), .PS2_DAT(pad_dat),
    .ps2_clk_oe(clk_oe), .ps2_dat_oe(dat_oe), .tx_done(tx_done), .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0, total = 0;
  bit active = 1'b0;
  int acc = 0, endc = 0, kind = 0, nf = 0;
  int falls [1:11];
  logic [9:0] ebits = '0;
  int done_cnt = 0, err_cnt = 0, inh_obs = 0, err_cyc = 0, rel_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  task automatic bound_fail(input string name);
    total++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // kind: 0 = abandoned by reset, 1 = done, 2 = error
  always @(posedge clk) begin
    int c, k;
    logic e_clk, e_dat, e_rdy, e_done, e_err;
    #2;
    c = cyc;
    e_clk = 0; e_dat = 0; e_rdy = 1; e_done = 0; e_err = 0;
    if (active && c >= acc && c < endc) begin
      e_rdy = 0;
      if (c < acc + N) begin
        e_clk = 1;
      end else begin
        k = 0;
        for (int i = 1; i <= nf; i++) if (falls[i] + LAT <= c) k = i;
        e_dat = (k == 0) ? 1'b1 : ((k <= 10) ? ~ebits[k-1] : 1'b0);
      end
    end else if (active && c == endc) begin
      e_done = (kind == 1);
      e_err  = (kind == 2);
    end
    chk("tx_ready", tx_ready, e_rdy);
    chk("clk_oe", clk_oe, e_clk);
    chk("dat_oe", dat_oe, e_dat);
    chk("tx_done", tx_done, e_done);
    chk("tx_error", tx_error, e_err);
    if (tx_done) done_cnt++;
    if (tx_error) begin err_cnt++; err_cyc = c; end
    if (clk_oe) inh_obs++;
  end

  task automatic send(input logic [7:0] d);
    int ones;
    ones = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    ebits = {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
    acc = cyc + 1; endc = acc + N + T; kind = 2; nf = 0;
    inh_obs = 0; done_cnt = 0; err_cnt = 0; active = 1'b1;
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk);
    tx_data = ~d;                       // late data change and valid outside IDLE must be ignored
    repeat (4) @(negedge clk);
    tx_valid = 1'b0; tx_data = 8'h00;
  endtask

  task automatic device(input int nfalls, input bit ack, input bit glitch,
                        input int abort_at, output logic [9:0] seen);
    int w;
    seen = '0;
    w = 0;
    do begin @(negedge clk); w++; end while (!(cyc > acc && !clk_oe) && w < N + 100);
    if (w >= N + 100) begin bound_fail("clk_release"); return; end
    rel_cyc = cyc;
    chk("release_cycle", cyc, acc + N);
    repeat (HALF) @(negedge clk);
    chk("start_bit", pad_dat, 0);
    for (int k = 1; k <= nfalls; k++) begin
      dev_clk = 1'b0; falls[k] = cyc; nf = k;
      if (k == abort_at) begin
        reset = 1'b1; endc = cyc + 1; kind = 0;
        @(negedge clk);
        reset = 1'b0; dev_clk = 1'b1; dev_dat = 1'b1;
        return;
      end
      if (k == 11) begin
        if (ack) dev_dat = 1'b0;
        else endc = cyc + LAT;
      end
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (k <= 10) seen[k-1] = pad_dat;
      if (k == 11) begin
        dev_dat = 1'b1;
        if (ack) begin endc = cyc + LAT + 1; kind = 1; end
      end
      if (glitch && k <= 10) begin
        repeat (5) @(negedge clk); dev_clk = 1'b0;
        repeat (3) @(negedge clk); dev_clk = 1'b1;
        repeat (HALF - 8) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  task automatic wait_end();
    int w;
    w = 0;
    while (cyc <= endc + 2 && w < T + 1000) begin @(negedge clk); w++; end
    if (w >= T + 1000) bound_fail("frame_end");
    repeat (30) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [9:0] seen;
    // 1: reset
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", tx_ready, 1);
    chk("rst_clk_oe", clk_oe, 0);
    chk("rst_dat_oe", dat_oe, 0);
    chk("rst_pulses", {tx_done, tx_error}, 0);
    repeat (10) @(negedge clk);

    // 2: 0xED with ACK
    send(8'hED);
    device(11, 1'b1, 1'b0, 0, seen);
    wait_end();
    chk("model_bits_ed", ebits, 10'h3ED);
    chk("bits_ed", seen, 10'h3ED);
    chk("inhibit_len", inh_obs, 60);
    chk("done_cnt_ed", done_cnt, 1);
    chk("err_cnt_ed", err_cnt, 0);

    // 3: 0x00 with NACK
    send(8'h00);
    device(11, 1'b0, 1'b0, 0, seen);
    wait_end();
    chk("bits_00", seen, 10'h300);
    chk("done_cnt_00", done_cnt, 0);
    chk("err_cnt_00", err_cnt, 1);
    chk("idle_ready_00", tx_ready, 1);

    // 4: 0xFF, device stops after fall 5
    send(8'hFF);
    device(5, 1'b1, 1'b0, 0, seen);
    wait_end();
    chk("timeout_dist", err_cyc - rel_cyc, 2000);
    chk("err_cnt_ff", err_cnt, 1);
    chk("done_cnt_ff", done_cnt, 0);
    chk("oe_after_to", {clk_oe, dat_oe}, 0);

    // 5: 0x01 with clock glitches
    send(8'h01);
    device(11, 1'b1, 1'b1, 0, seen);
    wait_end();
    chk("bits_01", seen, 10'h201);
    chk("done_cnt_01", done_cnt, 1);
    chk("err_cnt_01", err_cnt, 0);

    // 6: reset at fall 6, then 0xF4 completes
    send(8'hA5);
    device(11, 1'b1, 1'b0, 6, seen);
    chk("abort_clk_oe", clk_oe, 0);
    chk("abort_dat_oe", dat_oe, 0);
    repeat (40) @(negedge clk);
    chk("abort_pulses", done_cnt + err_cnt, 0);
    send(8'hF4);
    device(11, 1'b1, 1'b0, 0, seen);
    wait_end();
    chk("bits_f4", seen, 10'h2F4);
    chk("done_cnt_f4", done_cnt, 1);
    chk("err_cnt_f4", err_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
